// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word memory responder with a fixed,
// parameterised response latency. A request is accepted in IDLE, waits out
// the latency in WAIT, and its response is held in RESP until the core
// takes it. The memory array is read or written on the edge that enters RESP.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new request (req_ready = 1)
//   WAIT  | request latched, latency counter running down
//   RESP  | response registered and presented (resp_valid = 1)
module dmem_responder #(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;

  logic              r_we;
  logic [DWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;

  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;

  logic              w_op_we;
  logic [DWIDTH-1:0] w_op_addr;
  logic [DWIDTH-1:0] w_op_wdata;
  logic [AW-1:0]     w_op_idx;
  logic              w_op_err;

  // Operand of the access performed on the edge entering RESP. With a
  // latency of one that edge is the acceptance edge itself, so the live
  // request inputs are used; otherwise the latched copy is used.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_op_we    = req_we;
      w_op_addr  = req_addr;
      w_op_wdata = req_wdata;
    end else begin
      w_op_we    = r_we;
      w_op_addr  = r_addr;
      w_op_wdata = r_wdata;
    end
  end

  // Word index and error decode: misaligned, or any address bit above the
  // word index set (which would otherwise alias onto a stored word).
  always_comb begin
    w_op_idx = w_op_addr[AW+1:2];
    w_op_err = (w_op_addr[1:0] != 2'b00) || ((w_op_addr >> (AW + 2)) != '0);
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY > 1) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt  = S_RESP;
            w_cnt_nxt    = '0;
            w_enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A zero count can only be reached through a corrupted state; treat
        // it like the terminal count so the FSM can never stall in WAIT.
        if (r_cnt <= CW'(1)) begin
          w_state_nxt  = S_RESP;
          w_cnt_nxt    = '0;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latch; only updated on acceptance, so requests presented
  // outside IDLE cannot disturb the one in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response registers; loaded once on entry to RESP and held until the
  // next entry, which keeps them stable across any resp_ready stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err <= w_op_err;
      if (!w_op_we && !w_op_err) begin
        r_rdata <= r_mem[w_op_idx];
      end else begin
        r_rdata <= '0;
      end
    end
  end

  // Storage array; never reset. The rst term drops a store whose RESP
  // entry coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_op_we && !w_op_err) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset and
// LATENCY=1 sequences, then randomized traffic against a word-array model.
module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [DW-1:0] req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;

  logic          req_valid1, req_ready1, req_we1;
  logic [DW-1:0] req_addr1, req_wdata1;
  logic          resp_valid1, resp_ready1, resp_err1;
  logic [DW-1:0] resp_rdata1;

  dmem_responder #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain word array plus a written flag per word.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];

  function automatic bit m_is_err(input logic [DW-1:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance. Entered and left just
  // after a rising edge with the DUT expected in IDLE.
  task automatic run_req(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input int stall, input logic [DW-1:0] exp_rdata, input bit exp_err,
                         input string tag);
    int lat;
    check({tag, "/req_ready_idle"}, req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    // garbage requests while waiting must be ignored
    req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end
    check({tag, "/latency"}, lat, LAT);
    check({tag, "/resp_err"}, resp_err, exp_err);
    check({tag, "/resp_rdata"}, resp_rdata, exp_rdata);
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      check({tag, "/stall_valid"}, resp_valid, 1);
      check({tag, "/stall_req_ready"}, req_ready, 0);
      check({tag, "/stall_rdata"}, resp_rdata, exp_rdata);
      check({tag, "/stall_err"}, resp_err, exp_err);
    end
    req_valid  = 1'($urandom);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check({tag, "/done_req_ready"}, req_ready, 1);
    check({tag, "/done_resp_valid"}, resp_valid, 0);
    if (we && !m_is_err(addr)) begin
      m_mem[addr / 4]   = wdata;
      m_known[addr / 4] = 1'b1;
    end
  endtask

  typedef struct {
    bit            we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            stall;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit            we;
    logic [DW-1:0] addr, wdata, exp_rd;
    int            w, kind;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_2222, 1, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h5555_5555, 0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         5, 32'h1111_2222, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_03FE, 32'h7777_7777, 2, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0,         0, 32'h0BAD_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hCAFE_0008, 0, 32'h0,         1'b0});

    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset/req_ready", req_ready, 1);
    check("reset/resp_valid", resp_valid, 0);
    check("reset/resp_rdata", resp_rdata, 0);
    check("reset/resp_err", resp_err, 0);
    check("reset/lat1_req_ready", req_ready1, 1);
    check("reset/lat1_resp_valid", resp_valid1, 0);

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // reset while a store to 0x20 is in WAIT: dropped, no response
    run_req(1'b0, 32'h0000_03FC, 32'h0, 0, 32'h0BAD_F00D, 1'b0, "pre_rst_load");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_wait/in_wait_valid", resp_valid, 0);
    check("rst_wait/in_wait_ready", req_ready, 0);
    rst = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b0;
    check("rst_wait/req_ready", req_ready, 1);
    check("rst_wait/resp_valid", resp_valid, 0);
    check("rst_wait/resp_rdata", resp_rdata, 0);
    check("rst_wait/resp_err", resp_err, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst_wait/no_resp", resp_valid, 0);
    end
    run_req(1'b0, 32'h0000_0020, 32'h0, 0, 32'hCAFE_0008, 1'b0, "rst_wait_word8");

    // LATENCY=1: back-to-back store then load of 0xFC, resp_ready tied high
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'hFC; req_wdata1 = 32'hA5A5_5A5A;
    check("lat1/st_ready", req_ready1, 1);
    @(posedge clk); #1;
    check("lat1/st_resp_valid", resp_valid1, 1);
    check("lat1/st_resp_err", resp_err1, 0);
    check("lat1/st_resp_rdata", resp_rdata1, 0);
    check("lat1/st_req_ready", req_ready1, 0);
    req_we1 = 1'b0; req_wdata1 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("lat1/gap_resp_valid", resp_valid1, 0);
    check("lat1/gap_req_ready", req_ready1, 1);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check("lat1/ld_resp_valid", resp_valid1, 1);
    check("lat1/ld_resp_rdata", resp_rdata1, 32'hA5A5_5A5A);
    check("lat1/ld_resp_err", resp_err1, 0);
    @(posedge clk); #1;
    check("lat1/end_req_ready", req_ready1, 1);
    check("lat1/end_resp_valid", resp_valid1, 0);

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) w = $urandom_range(0, 15);
      else w = DEPTH - 1 - $urandom_range(0, 7);
      if (kind <= 6) begin
        addr = 32'(w * 4);
      end else if (kind == 7) begin
        addr = 32'(w * 4 + $urandom_range(1, 3));
      end else begin
        addr = $urandom;
        if (addr < 32'(DEPTH * 4)) addr = addr + 32'(DEPTH * 4);
      end
      we    = 1'($urandom);
      wdata = $urandom;
      if (!we && !m_is_err(addr) && !m_known[addr / 4]) we = 1'b1;
      if (!we && !m_is_err(addr)) exp_rd = m_mem[addr / 4];
      else exp_rd = '0;
      run_req(we, addr, wdata, $urandom_range(0, 3), exp_rd, m_is_err(addr),
              $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
